// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with a two-entry skid buffer.
// Sits between two CPU stages. A stall comes from backpressure. flush drops every
// held entry. Empty entries hold BUBBLE so that an idle stage presents a NOP.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      discard all held entries at the next edge
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload (depends on registered state and rst only)
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts this cycle
//   out_data   payload to the next stage (BUBBLE when empty)
//   occupancy  number of held entries (0, 1 or 2)
module pipe_stage_reg #(
   parameter int unsigned       DATA_W = 64,
   parameter logic [DATA_W-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mainReg;
   logic [DATA_W-1:0] skidReg;
   logic              inFire;
   logic              outFire;

   // Handshake outputs come from registered state only; there is no path from out_ready or in_valid.
   assign in_ready  = ~rst & (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = mainReg;
   assign inFire    = in_valid & in_ready;
   assign outFire   = out_valid & out_ready;

   // Entry count decoded from the state.
   always_comb begin
      occupancy = 2'd0;
      unique case (state)
         EMPTY:   occupancy = 2'd0;
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // Stage control. main always holds the older entry. Flush has priority over
   // everything else. An out_fire in the same cycle still completes, because
   // downstream already owns that payload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         mainReg <= BUBBLE;
         skidReg <= BUBBLE;
      end else if (flush) begin
         state   <= EMPTY;
         mainReg <= BUBBLE;
         skidReg <= BUBBLE;
      end else begin
         unique case (state)
            EMPTY: begin
               if (inFire) begin
                  mainReg <= in_data;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (inFire && outFire) begin
                  mainReg <= in_data;
               end else if (inFire) begin
                  skidReg <= in_data;
                  state   <= FULL;
               end else if (outFire) begin
                  mainReg <= BUBBLE;
                  state   <= EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (outFire) begin
                  mainReg <= skidReg;
                  skidReg <= BUBBLE;
                  state   <= ONE;
               end
            end
            default: begin
               state   <= EMPTY;
               mainReg <= BUBBLE;
               skidReg <= BUBBLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives two stage instances (BUBBLE=0 and BUBBLE=0x13) with
// shared stimulus. Expected values come from a queue-based model of a
// two-entry FIFO with flush.
module tb_pipe_stage_reg;

   localparam logic [63:0] BUB_A = 64'h0;
   localparam logic [63:0] BUB_B = 64'h13;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        inValid;
   logic [63:0] inData;
   logic        outReady;

   logic        aInReady, aOutValid, bInReady, bOutValid;
   logic [63:0] aOutData, bOutData;
   logic [1:0]  aOcc, bOcc;

   int checks = 0;
   int errors = 0;

   logic [63:0] q[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(64), .BUBBLE(BUB_A)) dutA (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(inValid), .in_ready(aInReady), .in_data(inData),
      .out_valid(aOutValid), .out_ready(outReady), .out_data(aOutData),
      .occupancy(aOcc)
   );

   pipe_stage_reg #(.DATA_W(64), .BUBBLE(BUB_B)) dutB (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(inValid), .in_ready(bInReady), .in_data(inData),
      .out_valid(bOutValid), .out_ready(outReady), .out_data(bOutData),
      .occupancy(bOcc)
   );

   // Model views of the FIFO contents.
   function automatic logic [63:0] mData(input logic [63:0] bub);
      return (q.size() > 0) ? q[0] : bub;
   endfunction

   function automatic logic mValid();
      return q.size() > 0;
   endfunction

   function automatic logic [1:0] mOcc();
      return 2'(q.size());
   endfunction

   function automatic logic mReady();
      return (q.size() < 2) && !rst;
   endfunction

   // Apply one cycle of stimulus. Advance the model at the edge, then settle #1 after it.
   task automatic step(input logic v, input logic [63:0] d, input logic r, input logic f);
      logic mIn, mOut;
      inValid  = v;
      inData   = d;
      outReady = r;
      flush    = f;
      mIn  = v && mReady();
      mOut = r && mValid();
      @(posedge clk);
      if (mOut) void'(q.pop_front());
      if (f) q.delete();
      else if (mIn) q.push_back(d);
      #1;
   endtask

   task automatic test_reset();
      // Fill to FULL with 0xA, 0xB, then assert reset asynchronously mid-cycle.
      step(1'b1, 64'hA, 1'b0, 1'b0);
      step(1'b1, 64'hB, 1'b0, 1'b0);
      checks++;
      if (aOcc !== 2'd2) begin errors++; $display("FAIL reset_prefill_occ act=%0d exp=2", aOcc); end
      #2 rst = 1'b1;
      q.delete();
      #1;
      checks++;
      if (aOutValid !== 1'b0) begin errors++; $display("FAIL reset_valid act=%b exp=0", aOutValid); end
      checks++;
      if (aOutData !== BUB_A) begin errors++; $display("FAIL reset_data_a act=%h exp=%h", aOutData, BUB_A); end
      checks++;
      if (bOutData !== BUB_B) begin errors++; $display("FAIL reset_data_b act=%h exp=%h", bOutData, BUB_B); end
      checks++;
      if (aOcc !== 2'd0) begin errors++; $display("FAIL reset_occ act=%0d exp=0", aOcc); end
      checks++;
      if (aInReady !== 1'b0 || bInReady !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready act=%b%b exp=00", aInReady, bInReady);
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 64'h0, 1'b0, 1'b0);
      checks++;
      if (aInReady !== 1'b1) begin errors++; $display("FAIL reset_release_ready act=%b exp=1", aInReady); end
      checks++;
      if (bOutData !== BUB_B) begin errors++; $display("FAIL reset_release_bubble act=%h exp=%h", bOutData, BUB_B); end
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 64'(i), 1'b1, 1'b0);
         checks++;
         if (aOutData !== 64'(i) || aOutValid !== 1'b1) begin
            errors++; $display("FAIL stream_data[%0d] act=%h/%b exp=%h/1", i, aOutData, aOutValid, 64'(i));
         end
         checks++;
         if (aOcc !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] act=%0d exp=1", i, aOcc); end
      end
      step(1'b0, 64'h0, 1'b1, 1'b0);
      checks++;
      if (bOutData !== BUB_B || bOutValid !== 1'b0) begin
         errors++; $display("FAIL stream_drain_bubble act=%h/%b exp=%h/0", bOutData, bOutValid, BUB_B);
      end
   endtask

   task automatic test_skid();
      step(1'b1, 64'h10, 1'b1, 1'b0);
      step(1'b1, 64'h11, 1'b0, 1'b0);
      checks++;
      if (aOcc !== 2'd2 || aInReady !== 1'b0 || aOutData !== 64'h10) begin
         errors++; $display("FAIL skid_full act=occ%0d rdy%b d%h exp=occ2 rdy0 d10", aOcc, aInReady, aOutData);
      end
      step(1'b1, 64'h99, 1'b1, 1'b0);   // in_ready is low, so 0x99 must be ignored
      checks++;
      if (aOutData !== 64'h11 || aOcc !== 2'd1) begin
         errors++; $display("FAIL skid_drain1 act=d%h occ%0d exp=d11 occ1", aOutData, aOcc);
      end
      step(1'b0, 64'h0, 1'b1, 1'b0);
      checks++;
      if (aOcc !== 2'd0 || bOutData !== BUB_B) begin
         errors++; $display("FAIL skid_drain2 act=occ%0d d%h exp=occ0 d%h", aOcc, bOutData, BUB_B);
      end
   endtask

   task automatic test_flush_priority();
      step(1'b1, 64'h20, 1'b0, 1'b0);
      checks++;
      if (aOutValid !== 1'b1 || aOutData !== 64'h20) begin
         errors++; $display("FAIL flushpri_pre act=%b/%h exp=1/20", aOutValid, aOutData);
      end
      step(1'b1, 64'h21, 1'b1, 1'b1);
      checks++;
      if (aOutValid !== 1'b0 || aOutData !== BUB_A || bOutData !== BUB_B) begin
         errors++; $display("FAIL flushpri_post act=%b/%h/%h exp=0/%h/%h", aOutValid, aOutData, bOutData, BUB_A, BUB_B);
      end
   endtask

   task automatic test_flush_full();
      step(1'b1, 64'h2A, 1'b0, 1'b0);
      step(1'b1, 64'h2B, 1'b0, 1'b0);
      step(1'b0, 64'h0, 1'b0, 1'b1);
      checks++;
      if (aOcc !== 2'd0 || aInReady !== 1'b1) begin
         errors++; $display("FAIL flushfull act=occ%0d rdy%b exp=occ0 rdy1", aOcc, aInReady);
      end
      step(1'b1, 64'h30, 1'b0, 1'b0);
      checks++;
      if (aOutData !== 64'h30 || aOcc !== 2'd1) begin
         errors++; $display("FAIL flushfull_next act=%h occ%0d exp=30 occ1", aOutData, aOcc);
      end
      // Flush held for several cycles: every input is accepted and dropped.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 64'h40 + 64'(i), 1'b0, 1'b1);
         checks++;
         if (aOcc !== 2'd0 || bOutData !== BUB_B) begin
            errors++; $display("FAIL flushhold[%0d] act=occ%0d d%h exp=occ0 d%h", i, aOcc, bOutData, BUB_B);
         end
      end
      step(1'b0, 64'h0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 3) != 0, {$urandom, $urandom},
              $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         checks++;
         if (aOutData !== mData(BUB_A) || bOutData !== mData(BUB_B)) begin
            errors++; $display("FAIL rand_data[%0d] act=%h/%h exp=%h/%h", n, aOutData, bOutData, mData(BUB_A), mData(BUB_B));
         end
         checks++;
         if (aOutValid !== mValid() || bOutValid !== mValid()) begin
            errors++; $display("FAIL rand_valid[%0d] act=%b%b exp=%b", n, aOutValid, bOutValid, mValid());
         end
         checks++;
         if (aOcc !== mOcc() || bOcc !== mOcc()) begin
            errors++; $display("FAIL rand_occ[%0d] act=%0d/%0d exp=%0d", n, aOcc, bOcc, mOcc());
         end
         checks++;
         if (aInReady !== mReady() || bInReady !== mReady()) begin
            errors++; $display("FAIL rand_ready[%0d] act=%b%b exp=%b", n, aInReady, bInReady, mReady());
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      inValid  = 1'b0;
      inData   = '0;
      outReady = 1'b0;
      #7;
      checks++;
      if (aOutValid !== 1'b0 || aInReady !== 1'b0 || aOcc !== 2'd0 || bOutData !== BUB_B) begin
         errors++; $display("FAIL initial_reset act=v%b r%b o%0d d%h", aOutValid, aInReady, aOcc, bOutData);
      end
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_streaming();
      test_skid();
      test_flush_priority();
      test_flush_full();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
